// File: rtl/rgmii_tx_nibble_gen.sv
// RGMII transmit launch logic: turns one GMII byte per slot into per-cycle rise/fall
// values for TXD, TX_CTL and TXC, stretching slots for 100M/10M from a 125 MHz clock.
module rgmii_tx_nibble_gen (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] speed_i,
    input  logic       tx_v_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_er_i,
    output logic       tx_ready_o,
    output logic [3:0] rgmii_txd_r_o,
    output logic [3:0] rgmii_txd_f_o,
    output logic       rgmii_tx_ctl_r_o,
    output logic       rgmii_tx_ctl_f_o,
    output logic       rgmii_txc_r_o,
    output logic       rgmii_txc_f_o
);

    typedef enum logic [1:0] {
        SPD_10       = 2'b00,
        SPD_100      = 2'b01,
        SPD_1000     = 2'b10,
        SPD_1000_ALT = 2'b11
    } speed_t;

    function automatic logic [6:0] slot_last(input speed_t s);
        case (s)
            SPD_100: slot_last = 7'd9;
            SPD_10:  slot_last = 7'd99;
            default: slot_last = 7'd0;
        endcase
    endfunction

    function automatic logic [6:0] half_period(input speed_t s);
        case (s)
            SPD_100: half_period = 7'd5;
            SPD_10:  half_period = 7'd50;
            default: half_period = 7'd1;
        endcase
    endfunction

    speed_t     speed_r, speed_n;
    logic [6:0] cnt_r, cnt_n;
    logic [7:0] byte_r, byte_n;
    logic       en_r, en_n;
    logic       er_r, er_n;

    logic [6:0] p_n;
    logic [6:0] k_n;
    logic [7:0] h_rise_n;
    logic [7:0] h_fall_n;
    logic [3:0] nib_n;
    logic       gig_n;

    logic       ready_n;
    logic [3:0] txd_r_n, txd_f_n;
    logic       ctl_r_n, ctl_f_n;
    logic       txc_r_n, txc_f_n;

    always_comb begin
        speed_n = speed_r;
        cnt_n   = cnt_r + 7'd1;
        byte_n  = byte_r;
        en_n    = en_r;
        er_n    = er_r;
        if (cnt_r == slot_last(speed_r)) begin
            cnt_n   = '0;
            speed_n = speed_t'(speed_i);
            if (tx_v_i) begin
                byte_n = tx_data_i;
                en_n   = 1'b1;
                er_n   = tx_er_i;
            end else begin
                byte_n = '0;
                en_n   = 1'b0;
                er_n   = 1'b0;
            end
        end
    end

    // Outputs are registered from the next-state values so each flop shows the
    // encoding of the current slot position with no extra cycle of latency.
    always_comb begin
        gig_n    = (speed_n == SPD_1000) || (speed_n == SPD_1000_ALT);
        p_n      = half_period(speed_n);
        k_n      = (cnt_n >= p_n) ? (cnt_n - p_n) : cnt_n;
        h_rise_n = {k_n, 1'b0};
        h_fall_n = {k_n, 1'b1};
        nib_n    = (cnt_n < p_n) ? byte_n[3:0] : byte_n[7:4];
        ready_n  = (cnt_n == slot_last(speed_n));
        ctl_r_n  = en_n;
        ctl_f_n  = en_n ^ er_n;
        if (gig_n) begin
            txd_r_n = byte_n[3:0];
            txd_f_n = byte_n[7:4];
            txc_r_n = 1'b1;
            txc_f_n = 1'b0;
        end else begin
            txd_r_n = nib_n;
            txd_f_n = nib_n;
            txc_r_n = (h_rise_n >= {1'b0, p_n});
            txc_f_n = (h_fall_n >= {1'b0, p_n});
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            speed_r          <= SPD_1000;
            cnt_r            <= '0;
            byte_r           <= '0;
            en_r             <= 1'b0;
            er_r             <= 1'b0;
            tx_ready_o       <= 1'b1;
            rgmii_txd_r_o    <= '0;
            rgmii_txd_f_o    <= '0;
            rgmii_tx_ctl_r_o <= 1'b0;
            rgmii_tx_ctl_f_o <= 1'b0;
            rgmii_txc_r_o    <= 1'b0;
            rgmii_txc_f_o    <= 1'b0;
        end else begin
            speed_r          <= speed_n;
            cnt_r            <= cnt_n;
            byte_r           <= byte_n;
            en_r             <= en_n;
            er_r             <= er_n;
            tx_ready_o       <= ready_n;
            rgmii_txd_r_o    <= txd_r_n;
            rgmii_txd_f_o    <= txd_f_n;
            rgmii_tx_ctl_r_o <= ctl_r_n;
            rgmii_tx_ctl_f_o <= ctl_f_n;
            rgmii_txc_r_o    <= txc_r_n;
            rgmii_txc_f_o    <= txc_f_n;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_nibble_gen.sv
// Bench for rgmii_tx_nibble_gen: a slot-level queue model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_rgmii_tx_nibble_gen;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [1:0] speed_i = 2'b10;
    logic       tx_v_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_er_i = 1'b0;
    logic       tx_ready_o;
    logic [3:0] rgmii_txd_r_o, rgmii_txd_f_o;
    logic       rgmii_tx_ctl_r_o, rgmii_tx_ctl_f_o;
    logic       rgmii_txc_r_o, rgmii_txc_f_o;

    int checks = 0;
    int errors = 0;

    rgmii_tx_nibble_gen dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .speed_i         (speed_i),
        .tx_v_i          (tx_v_i),
        .tx_data_i       (tx_data_i),
        .tx_er_i         (tx_er_i),
        .tx_ready_o      (tx_ready_o),
        .rgmii_txd_r_o   (rgmii_txd_r_o),
        .rgmii_txd_f_o   (rgmii_txd_f_o),
        .rgmii_tx_ctl_r_o(rgmii_tx_ctl_r_o),
        .rgmii_tx_ctl_f_o(rgmii_tx_ctl_f_o),
        .rgmii_txc_r_o   (rgmii_txc_r_o),
        .rgmii_txc_f_o   (rgmii_txc_f_o)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [3:0] txd_r;
        logic [3:0] txd_f;
        logic       ctl_r;
        logic       ctl_f;
        logic       txc_r;
        logic       txc_f;
        logic       ready;
    } exp_t;

    // One queue entry per upcoming cycle; a new slot is generated whenever it runs dry.
    exp_t q[$];

    function automatic void fill_slot();
        int   len, p, k;
        exp_t e;
        logic [7:0] d;
        logic er;
        case (speed_i)
            2'b01:   len = 10;
            2'b00:   len = 100;
            default: len = 1;
        endcase
        d  = tx_v_i ? tx_data_i : 8'h00;
        er = tx_v_i & tx_er_i;
        for (int c = 0; c < len; c++) begin
            e = '0;
            e.ctl_r = tx_v_i;
            e.ctl_f = tx_v_i ^ er;
            e.ready = (c == len - 1);
            if (len == 1) begin
                e.txd_r = d[3:0];
                e.txd_f = d[7:4];
                e.txc_r = 1'b1;
                e.txc_f = 1'b0;
            end else begin
                p = len / 2;
                k = c % p;
                e.txd_r = (c < p) ? d[3:0] : d[7:4];
                e.txd_f = e.txd_r;
                e.txc_r = (2 * k >= p);
                e.txc_f = (2 * k + 1 >= p);
            end
            q.push_back(e);
        end
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            exp_t e;
            e = '0;
            e.ready = 1'b1;
            q.delete();
            q.push_back(e);
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (q.size() == 0) fill_slot();
        end
    end

    always @(negedge clk) begin
        if (!reset_i && q.size() > 0) begin
            exp_t act;
            act = {rgmii_txd_r_o, rgmii_txd_f_o, rgmii_tx_ctl_r_o, rgmii_tx_ctl_f_o,
                   rgmii_txc_r_o, rgmii_txc_f_o, tx_ready_o};
            checks++;
            if (act !== q[0]) begin
                errors++;
                $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, act, q[0]);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input int txr, input int txf, input int cr,
                            input int cf, input int kr, input int kf, input int rdy);
        chk({nm, "_txd_r"}, rgmii_txd_r_o, txr);
        chk({nm, "_txd_f"}, rgmii_txd_f_o, txf);
        chk({nm, "_ctl_r"}, rgmii_tx_ctl_r_o, cr);
        chk({nm, "_ctl_f"}, rgmii_tx_ctl_f_o, cf);
        chk({nm, "_txc_r"}, rgmii_txc_r_o, kr);
        chk({nm, "_txc_f"}, rgmii_txc_f_o, kf);
        chk({nm, "_ready"}, tx_ready_o, rdy);
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        bit ok;
        ok = 0;
        tx_v_i = 1'b1;
        tx_data_i = d;
        tx_er_i = e;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (tx_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout t=%0t got=no_ready expected=ready", $time);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic slot_len(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (tx_ready_o) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1);
    end

    int nib100[10] = '{5, 5, 5, 5, 5, 13, 13, 13, 13, 13};
    int kr100[10]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    int kf100[10]  = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};

    initial begin
        int n, hi, rd, ctl;
        #1 reset_i = 1'b1;
        repeat (2) @(negedge clk);
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 1);
        #1 reset_i = 1'b0;

        // 1000M: 0x5D then 0xA3
        @(posedge clk); #2;
        tx_v_i = 1'b1; tx_data_i = 8'h5D;
        @(posedge clk); #2;
        tx_data_i = 8'hA3;
        @(negedge clk);
        chk_outs("g_5d", 13, 5, 1, 1, 1, 0, 1);
        @(posedge clk); #2;
        tx_v_i = 1'b0;
        @(negedge clk);
        chk_outs("g_a3", 3, 10, 1, 1, 1, 0, 1);

        // 1000M: 0x55 with error, then idle
        @(posedge clk); #2;
        tx_v_i = 1'b1; tx_data_i = 8'h55; tx_er_i = 1'b1;
        @(posedge clk); #2;
        tx_v_i = 1'b0; tx_er_i = 1'b0;
        @(negedge clk);
        chk_outs("g_er", 5, 5, 1, 0, 1, 0, 1);
        @(negedge clk);
        chk_outs("g_idle", 0, 0, 0, 0, 1, 0, 1);

        // 100M: 0xD5
        speed_i = 2'b01;
        send(8'hD5, 1'b0);
        tx_v_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_outs("m_d5", nib100[c], nib100[c], 1, 1, kr100[c], kf100[c], (c == 9) ? 1 : 0);
        end

        // 10M idle
        speed_i = 2'b00;
        void'(slot_len(n));
        hi = 0; rd = 0; ctl = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rgmii_txc_r_o) hi++;
            if (tx_ready_o) rd++;
            if (rgmii_tx_ctl_r_o | rgmii_tx_ctl_f_o) ctl++;
        end
        chk("t_txc_high_cycles", hi, 50);
        chk("t_ready_pulses", rd, 1);
        chk("t_ready_last", tx_ready_o, 1);
        chk("t_ctl_cycles", ctl, 0);

        // Speed switches mid-stream
        speed_i = 2'b10;
        send(8'h11, 1'b0);
        speed_i = 2'b01;
        send(8'h22, 1'b0);
        tx_data_i = 8'h33;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (n == 4) speed_i = 2'b00;
            if (tx_ready_o) break;
        end
        chk("sw_100_slot_len", n, 10);
        @(posedge clk); #2;
        tx_v_i = 1'b0;
        slot_len(n);
        chk("sw_10_slot_len", n, 100);

        // Reset in the middle of a 100M slot
        speed_i = 2'b01;
        send(8'hC7, 1'b0);
        tx_v_i = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_ctl_r", rgmii_tx_ctl_r_o, 1);
        #1 reset_i = 1'b1;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 0, 0, 1);
        speed_i = 2'b10;
        @(posedge clk);
        @(negedge clk);
        #1 reset_i = 1'b0;
        #1;
        chk_outs("rst_release", 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #2;
        tx_v_i = 1'b1; tx_data_i = 8'h9E;
        @(posedge clk); #2;
        tx_v_i = 1'b0;
        @(negedge clk);
        chk_outs("post_rst_9e", 14, 9, 1, 1, 1, 0, 1);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
